// File: rtl/pwm_multi_if.sv
// Control/drive bundle for pwm_multi: the motor-control side drives the
// master modport, the PWM core sits on the slave modport.
interface pwm_multi_if #(
    parameter int WIDTH    = 11,
    parameter int CHANNELS = 2,
    parameter int DT_WIDTH = 4
);
    logic                      en;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      duty_vld;
    logic [DT_WIDTH-1:0]       dead;
    logic [CHANNELS-1:0]       pwm_hi;
    logic [CHANNELS-1:0]       pwm_lo;
    logic                      cycle_start;

    modport master (
        output en, period, duty, duty_vld, dead,
        input  pwm_hi, pwm_lo, cycle_start
    );

    modport slave (
        input  en, period, duty, duty_vld, dead,
        output pwm_hi, pwm_lo, cycle_start
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter, shadowed duty registers and
// complementary high/low drives separated by programmable dead-time.
module pwm_multi #(
    parameter int WIDTH    = 11,
    parameter int CHANNELS = 2,
    parameter int DT_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_multi_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_HI, S_LO} state_t;

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    per_act;
    logic [WIDTH-1:0]    per_eff;
    logic                en_q;
    logic                start;
    logic                wrap;
    logic                load;
    logic [WIDTH-1:0]    pend     [CHANNELS];
    logic [WIDTH-1:0]    act      [CHANNELS];
    logic [WIDTH-1:0]    load_val [CHANNELS];
    logic [WIDTH-1:0]    act_eff  [CHANNELS];
    logic [CHANNELS-1:0] raw_p0;
    state_t              st       [CHANNELS];
    logic                tgt      [CHANNELS];
    logic [DT_WIDTH-1:0] dt       [CHANNELS];
    logic [CHANNELS-1:0] hi_q;
    logic [CHANNELS-1:0] lo_q;
    logic                cs_q;

    function automatic logic [DT_WIDTH-1:0] dt_reload(input logic [DT_WIDTH-1:0] d);
        return d - DT_WIDTH'(1);
    endfunction

    // Stage p0: counter compare. The first enabled cycle acts like a wrap, so
    // the freshly loaded period and duties are already in force at cnt==0.
    always_comb begin
        start   = bus.en & ~en_q;
        per_eff = start ? bus.period : per_act;
        wrap    = bus.en & (cnt == per_eff);
        load    = start | wrap;
        for (int i = 0; i < CHANNELS; i++) begin
            load_val[i] = bus.duty_vld ? bus.duty[i*WIDTH +: WIDTH] : pend[i];
            act_eff[i]  = start ? load_val[i] : act[i];
            raw_p0[i]   = cnt < act_eff[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            per_act <= '0;
            en_q    <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            en_q <= bus.en;
            // Marks the cycle in which the drives first reflect cnt==0.
            cs_q <= bus.en & (cnt == '0);
            if (!bus.en || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
            if (load) begin
                per_act <= bus.period;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.duty_vld) begin
                    pend[i] <= bus.duty[i*WIDTH +: WIDTH];
                end
                if (load) begin
                    act[i] <= load_val[i];
                end
            end
        end
    end

    // Stage p1: per-channel drive FSM. hi/lo are only ever written as the
    // pairs 10, 01 or 00, so both sides can never be on together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]   <= S_IDLE;
                tgt[i]  <= 1'b0;
                dt[i]   <= '0;
                hi_q[i] <= 1'b0;
                lo_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!bus.en) begin
                    st[i]   <= S_IDLE;
                    hi_q[i] <= 1'b0;
                    lo_q[i] <= 1'b0;
                end else begin
                    unique case (st[i])
                        S_IDLE, S_HI, S_LO: begin
                            if (st[i] == S_IDLE || raw_p0[i] != (st[i] == S_HI)) begin
                                if (bus.dead == '0) begin
                                    st[i]   <= raw_p0[i] ? S_HI : S_LO;
                                    hi_q[i] <= raw_p0[i];
                                    lo_q[i] <= ~raw_p0[i];
                                end else begin
                                    st[i]   <= S_DEAD;
                                    tgt[i]  <= raw_p0[i];
                                    dt[i]   <= dt_reload(bus.dead);
                                    hi_q[i] <= 1'b0;
                                    lo_q[i] <= 1'b0;
                                end
                            end
                        end
                        S_DEAD: begin
                            if (raw_p0[i] != tgt[i]) begin
                                tgt[i] <= raw_p0[i];
                                dt[i]  <= dt_reload(bus.dead);
                            end else if (dt[i] == '0) begin
                                st[i]   <= tgt[i] ? S_HI : S_LO;
                                hi_q[i] <= tgt[i];
                                lo_q[i] <= ~tgt[i];
                            end else begin
                                dt[i] <= dt[i] - DT_WIDTH'(1);
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign bus.pwm_hi      = hi_q;
    assign bus.pwm_lo      = lo_q;
    assign bus.cycle_start = cs_q;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator. It is the next-generation successor to the single-channel 11-bit PWM used by the motor and actuator drivers. Every channel shares one programmable-period counter. Each channel adds shadowed, glitch-free duty updates at period boundaries and complementary high/low outputs with programmable dead-time insertion. It sits between the motor-control logic, which supplies duty values, and the H-bridge gate drive pins.

## Interface

- WIDTH, 11, bit width of the counter, period and each duty value
- CHANNELS, 2, number of independent PWM channels
- DT_WIDTH, 4, bit width of the dead-time value

- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; low forces the counter to 0 and all outputs low
- period  input  WIDTH  terminal count; the PWM period is period+1 cycles
- duty  input  CHANNELS*WIDTH  flattened duties; channel i is bits [i*WIDTH +: WIDTH]
- duty_vld  input  1  single-cycle strobe that captures all of duty into the shadow registers
- dead  input  DT_WIDTH  dead-time in cycles; both outputs are low for this many cycles between drives
- pwm_hi  output  CHANNELS  high-side drive, registered
- pwm_lo  output  CHANNELS  low-side drive, registered
- cycle_start  output  1  one-cycle pulse, registered

## Operation

- **Counter cnt:**
  - Held at 0 while en=0.
  - While en=1, increments by 1 each cycle.
  - When cnt==per_act, the next value is 0 (the wrap).
- **Period latch:** per_act loads from period at every wrap and on the first enabled cycle. Mid-period changes to period have no effect until the next wrap.
- **Shadow duty:**
  - duty_vld=1 writes duty into pend[]. The last strobe before a wrap wins.
  - At each wrap, act[] loads pend[]. If duty_vld=1 in the wrap cycle itself, act[] loads duty directly.
- **Raw compare:** raw[i] = (cnt < act[i]), unsigned.
  - act[i]=0 gives 0% duty.
  - act[i] > per_act gives 100% duty.
- **Per-channel state machine** (states IDLE, DEAD, HI, LO; target tgt; down-counter dt):
  - IDLE: both outputs 0. When en=1: if dead==0, go to HI or LO per raw; else go to DEAD with tgt=raw and dt=dead-1.
  - HI (hi=1, lo=0) or LO (hi=0, lo=1): when raw differs from the current drive:
    - dead==0: switch directly to the other drive state.
    - dead>0: go to DEAD with tgt=raw and dt=dead-1.
  - DEAD: both outputs 0.
    - If raw≠tgt: set tgt=raw and reload dt=dead-1.
    - Else if dt==0: go to the drive state for tgt.
    - Else: decrement dt.
  - dead is sampled only on entry to DEAD or on a reload.
  - en=0 in any state: go to IDLE on the next edge.
- **Safety invariant:** pwm_hi[i] & pwm_lo[i] is never 1, in any cycle, in any state.
- **cycle_start:** high exactly in each cycle where cnt==0 following a wrap or the 0→1 transition of en. It is low while en=0.
- **Reset values:**
  - cnt=0, per_act=0, pend[]=0, act[]=0.
  - All channels IDLE; dt=0, tgt=0.
  - pwm_hi=0, pwm_lo=0, cycle_start=0.

## Timing

- Compare-to-output latency is 1 cycle: raw evaluated while cnt==k is visible on the outputs after the next edge.
- Steady-state widths, with dead>0 and 0 < duty ≤ per_act:
  - High time: duty−dead cycles.
  - Low time: per_act+1−duty−dead cycles.
  - Each of the two gaps: dead cycles.
  - A pulse narrower than dead produces no drive on that side; the channel stays in DEAD.
- New duty takes effect on the first period after the wrap that follows duty_vld, never mid-period. There is no glitch at the wrap.
- Outputs are registered. There is no combinational path from any input to any output.
- en 1→0: outputs are 0 and cnt is 0 after the next edge.
- en 0→1: cnt counts from 0, and the first drive appears after 1 cycle plus dead cycles.
- rst_n low asynchronously clears all state immediately, mid-period included. Operation resumes from the IDLE state and cnt=0 after release.
- per_act=0: cnt stays at 0 and cycle_start stays high every cycle. Outputs are static per raw.

## Test plan

- **Basic period:** WIDTH=11, period=9, dead=0, duty ch0=3, ch1=8 → repeating 10-cycle pattern.
  - ch0: pwm_hi high 3 cycles, then pwm_lo 7 cycles.
  - ch1: pwm_hi 8 cycles, then pwm_lo 2 cycles.
  - cycle_start pulses every 10 cycles.
- **Dead time:** period=9, dead=2, duty=5 → pwm_hi 3, both low 2, pwm_lo 3, both low 2. The assertion hi&lo==0 holds throughout.
- **Shadow update:** duty ch0=3 running; duty_vld with 7 at cnt=4, then with 6 at cnt=6 → current period keeps 3; the next period has high time 6. duty_vld asserted in the wrap cycle applies in the immediately following period.
- **Extremes:** duty=0 → pwm_hi never asserts. duty=2047 with period=9 → pwm_hi constant high after the startup dead-time, no drop at the wrap.
- **Period change:** period changed from 9 to 4 at cnt=5 → cnt continues to 9, then wraps. Subsequent periods are 5 cycles, and cycle_start spacing follows.
- **Disable/reset:** en dropped mid-pulse → all outputs 0 and cnt=0 after 1 edge. rst_n pulsed low mid-DEAD → outputs 0 immediately (asynchronous); after release with en=1, pwm_hi first asserts 1+dead cycles later.
